alu_unit: RTL and testbench

- 32-bit integer ALU for the datapath execute stage, MIPS-style 4-bit operation select.
- Computes a result from two operands and raises a zero flag (ZF) for branch decisions.
- Outputs are registered: one clock cycle of latency, synchronous active-low reset.

---
 rtl/alu_unit.sv | 106 ++++++++++
 tb/tb_alu_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: 32-bit MIPS-style execute-stage ALU with registered result,
// zero flag and signed-overflow flag (one cycle of latency).
// Optional multiplier on sel=1010 is compiled in when ALU_MULT_EN is defined;
// without it that code behaves like any other undefined opcode.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] res,
  output logic             ZF,
  output logic             OF
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic signed [WIDTH-1:0] w_op1_s;
  logic signed [WIDTH-1:0] w_op2_s;
  logic        [SHW-1:0]   w_shamt;
  logic        [WIDTH-1:0] w_sum;
  logic        [WIDTH-1:0] w_diff;
  logic                    w_add_of;
  logic                    w_sub_of;
  logic        [WIDTH-1:0] w_res;
  logic                    w_of;

  logic        [WIDTH-1:0] r_res;
  logic                    r_zf;
  logic                    r_of;

  assign w_op1_s = $signed(op1);
  assign w_op2_s = $signed(op2);
  assign w_shamt = op2[SHW-1:0];
  assign w_sum   = op1 + op2;
  assign w_diff  = op1 - op2;

  // Overflow only when operand signs make it possible and the result sign flips.
  assign w_add_of = (op1[WIDTH-1] == op2[WIDTH-1]) && (w_sum[WIDTH-1]  != op1[WIDTH-1]);
  assign w_sub_of = (op1[WIDTH-1] != op2[WIDTH-1]) && (w_diff[WIDTH-1] != op1[WIDTH-1]);

  // Next-result selection; undefined opcodes fall through to zero.
  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (sel)
      OP_AND:  w_res = op1 & op2;
      OP_OR:   w_res = op1 | op2;
      OP_ADD: begin
        w_res = w_sum;
        w_of  = w_add_of;
      end
      OP_XOR:  w_res = op1 ^ op2;
      OP_SLL:  w_res = op1 << w_shamt;
      OP_SRL:  w_res = op1 >> w_shamt;
      OP_SUB: begin
        w_res = w_diff;
        w_of  = w_sub_of;
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, (w_op1_s < w_op2_s)};
      OP_SRA:  w_res = $unsigned(w_op1_s >>> w_shamt);
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
`ifdef ALU_MULT_EN
      // Low half of the product is the same for signed and unsigned operands.
      OP_MUL:  w_res = op1 * op2;
`else
      OP_MUL:  w_res = '0;
`endif
      OP_NOR:  w_res = ~(op1 | op2);
      default: w_res = '0;
    endcase
  end

  // Output register; reset wins over any operation issued in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res <= '0;
      r_zf  <= 1'b1;
      r_of  <= 1'b0;
    end else begin
      r_res <= w_res;
      r_zf  <= (w_res == '0);
      r_of  <= w_of;
    end
  end

  assign res = r_res;
  assign ZF  = r_zf;
  assign OF  = r_of;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit with hand-computed
// expectations. The sel=1010 expectation follows ALU_MULT_EN.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  sel;
  logic [31:0] res;
  logic        ZF;
  logic        OF;

  int total = 0;
  int bad   = 0;

  alu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .op1   (op1),
    .op2   (op2),
    .sel   (sel),
    .res   (res),
    .ZF    (ZF),
    .OF    (OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one operation, then sample 1 time unit after the capturing edge.
  task automatic do_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    sel = s;
    op1 = a;
    op2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] r, input logic z, input logic o);
    chk({tag, ".res"}, res, r);
    chk({tag, ".ZF"},  {31'd0, ZF}, {31'd0, z});
    chk({tag, ".OF"},  {31'd0, OF}, {31'd0, o});
  endtask

  logic [31:0] mul_exp;

  initial begin
`ifdef ALU_MULT_EN
    mul_exp = 32'd42;
`else
    mul_exp = 32'd0;
`endif
    rst_n = 1'b0;
    sel   = 4'b0010;
    op1   = 32'd5;
    op2   = 32'd5;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 32'd0, 1'b1, 1'b0);

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rel_add", 32'd10, 1'b0, 1'b0);

    do_op(4'b0000, 32'd10, 32'd11);
    chk_all("and", 32'd10, 1'b0, 1'b0);
    do_op(4'b0001, 32'd12, 32'd13);
    chk_all("or", 32'd13, 1'b0, 1'b0);
    do_op(4'b1100, 32'd12, 32'd13);
    chk_all("nor", 32'hFFFF_FFF2, 1'b0, 1'b0);
    do_op(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk_all("xor", 32'h0FF0_0FF0, 1'b0, 1'b0);

    do_op(4'b0010, 32'd10, 32'd11);
    chk_all("add", 32'd21, 1'b0, 1'b0);
    do_op(4'b0110, 32'd12, 32'd13);
    chk_all("sub_neg", 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(4'b0110, 32'd7, 32'd7);
    chk_all("sub_zero", 32'd0, 1'b1, 1'b0);
    do_op(4'b0010, 32'h7FFF_FFFF, 32'd1);
    chk_all("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    do_op(4'b0010, 32'hFFFF_FFFF, 32'd1);
    chk_all("add_wrap", 32'd0, 1'b1, 1'b0);
    do_op(4'b0110, 32'h8000_0000, 32'd1);
    chk_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1);

    do_op(4'b0111, 32'd10, 32'd11);
    chk_all("slt", 32'd1, 1'b0, 1'b0);
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1);
    chk_all("slt_neg", 32'd1, 1'b0, 1'b0);
    do_op(4'b1001, 32'hFFFF_FFFF, 32'd1);
    chk_all("sltu", 32'd0, 1'b1, 1'b0);
    do_op(4'b0111, 32'h8000_0000, 32'd0);
    chk_all("slt_min", 32'd1, 1'b0, 1'b0);
    do_op(4'b1001, 32'h8000_0000, 32'd0);
    chk_all("sltu_min", 32'd0, 1'b1, 1'b0);

    do_op(4'b0100, 32'd1, 32'd31);
    chk_all("sll", 32'h8000_0000, 1'b0, 1'b0);
    do_op(4'b0101, 32'h8000_0000, 32'd4);
    chk_all("srl", 32'h0800_0000, 1'b0, 1'b0);
    do_op(4'b1000, 32'h8000_0000, 32'd4);
    chk_all("sra", 32'hF800_0000, 1'b0, 1'b0);
    do_op(4'b1000, 32'h8000_0001, 32'd0);
    chk_all("sra_zero", 32'h8000_0001, 1'b0, 1'b0);
    do_op(4'b0100, 32'h0000_0003, 32'h0000_0021);
    chk_all("sll_lowbits", 32'h0000_0006, 1'b0, 1'b0);

    do_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_all("undef", 32'd0, 1'b1, 1'b0);
    do_op(4'b1010, 32'd6, 32'd7);
    chk_all("mul", mul_exp, (mul_exp == 32'd0), 1'b0);

    // Reset issued alongside an operation must win.
    do_op(4'b0010, 32'h7FFF_FFFF, 32'd1);
    chk_all("pre_rst", 32'h8000_0000, 1'b0, 1'b1);
    rst_n = 1'b0;
    do_op(4'b0001, 32'd3, 32'd4);
    chk_all("rst_prio", 32'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    do_op(4'b0001, 32'd3, 32'd4);
    chk_all("post_rst", 32'd7, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
